// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

    // Detector states; IDLE means no legal pattern is loaded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    // Widest mask the helper can produce; callers truncate to their own width.
    localparam int MASK_W = 64;

    // Mask with the low 'len' bits set, used to ignore history bits above the pattern.
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Control/data/status bundle between the bit source, the detector and readout.
interface seq_pattern_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
);
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               inp_valid;
    logic               inp;
    logic               clr_cnt;
    logic               armed;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;

    // Source / controller side.
    modport master (
        output pat_load, pat_in, pat_len, overlap, inp_valid, inp, clr_cnt,
        input  armed, match, match_cnt
    );

    // Detector side.
    modport slave (
        input  pat_load, pat_in, pat_len, overlap, inp_valid, inp, clr_cnt,
        output armed, match, match_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-loadable serial pattern recogniser with overlap control, registered
// match pulse and saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    seq_pattern_detector_if.slave  bus
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic               match_q;
    logic               armed_q;

    logic [MAX_LEN-1:0] nxt_hist;
    logic [MAX_LEN-1:0] cmp_mask;
    logic [LEN_W:0]     fill_inc;
    logic               full;
    logic               load_ok;
    logic               accept;
    logic               hit;
    logic               cnt_clr;
    logic [CNT_W-1:0]   cnt;

    // Shift/compare datapath: candidate history and whether it completes the pattern.
    always_comb begin
        nxt_hist = {hist_q[MAX_LEN-2:0], bus.inp};
        fill_inc = {1'b0, fill_q} + 1'b1;
        full     = (fill_inc >= {1'b0, len_q});
        cmp_mask = MAX_LEN'(len_mask(int'(len_q)));
        load_ok  = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(MAX_LEN));
        // A load on the same edge drops the incoming bit.
        accept   = bus.inp_valid && !bus.pat_load && (state_q != ST_IDLE);
        hit      = accept && full && (((nxt_hist ^ pat_q) & cmp_mask) == '0);
        cnt_clr  = bus.clr_cnt || (bus.pat_load && load_ok);
    end

    // Next-state logic: load, accept-and-shift, non-overlap restart.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        if (bus.pat_load) begin
            if (load_ok) begin
                state_d = ST_FILL;
                pat_d   = bus.pat_in;
                len_d   = bus.pat_len;
                ovl_d   = bus.overlap;
                hist_d  = '0;
                fill_d  = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (accept) begin
            if (hit && !ovl_q) begin
                // Non-overlapping: matched bits cannot start the next match.
                state_d = ST_FILL;
                hist_d  = '0;
                fill_d  = '0;
            end else begin
                hist_d  = nxt_hist;
                fill_d  = full ? len_q : fill_inc[LEN_W-1:0];
                state_d = full ? ST_RUN : ST_FILL;
            end
        end
    end

    // State, history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= hit;
            armed_q <= (state_d != ST_IDLE);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (cnt_clr),
        .cnt   (cnt)
    );

    assign bus.match     = match_q;
    assign bus.armed     = armed_q;
    assign bus.match_cnt = cnt;

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial pattern recogniser and successor to the fixed 2-bit state-transition detector.
- Pattern and pattern length are runtime-loadable, up to MAX_LEN bits.
- Selectable overlapping or non-overlapping match mode, valid-qualified input, registered match pulse and saturating match counter.
- Sits between the serial bit source and the status/readout logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1): width of pat_len.
- CNT_W, 8: width of match_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pat_load  in  1  load strobe; captures pat_in, pat_len, overlap.
- pat_in  in  MAX_LEN  pattern; bit pat_len-1 is expected first, bit 0 last.
- pat_len  in  LEN_W  pattern length, legal 1..MAX_LEN.
- overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- inp_valid  in  1  inp is accepted on this edge.
- inp  in  1  serial data bit.
- clr_cnt  in  1  synchronous clear of match_cnt.
- armed  out  1  a legal pattern is loaded (state FILL or RUN).
- match  out  1  one-cycle registered pulse on pattern completion.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (async, rst_n=0): state IDLE; hist, fill_cnt, pattern, len, mode, match, match_cnt and armed all 0. Takes effect immediately mid-stream; no match is emitted for a partial stream.
- Internal state:
  - hist[MAX_LEN-1:0], the newest bit is hist[0].
  - fill_cnt, 0..pat_len.
  - captured pat_r, len_r, ovl_r.
- States: IDLE, FILL (fewer than len_r bits collected since load/restart), RUN (at least len_r bits held).
- Load:
  - pat_load with 1<=pat_len<=MAX_LEN captures pat_r/len_r/ovl_r, clears hist, fill_cnt and match_cnt, and goes to FILL.
  - An illegal pat_len (0 or >MAX_LEN) goes to IDLE and clears armed.
  - pat_load has priority over inp_valid on the same edge; that input bit is dropped.
- Accept: on an edge with inp_valid=1 in FILL/RUN, set nxt = {hist[MAX_LEN-2:0], inp}.
  - hist <= nxt.
  - fill_cnt <= min(fill_cnt+1, len_r).
  - FILL->RUN when fill_cnt+1 == len_r.
- Match condition: accepted bit, fill_cnt+1 >= len_r, and nxt[len_r-1:0] == pat_r[len_r-1:0]. Bits above len_r are masked.
- Match output: match=1 for exactly the cycle after the accepting edge (latency 1 clk), otherwise 0. Gaps with inp_valid=0 hold all state and do not break a partial pattern.
- Non-overlap mode (ovl_r=0): on a match, the same edge clears hist and fill_cnt and returns to FILL. Overlap mode keeps hist and stays in RUN.
- IDLE: inputs are ignored; match stays 0.
- Counter:
  - match_cnt increments on each match and saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 forces 0 and wins over a coincident match; the match pulse is still emitted.
- armed = (state != IDLE), registered.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package seq_det_pkg holds:
  - state encoding localparams ST_IDLE=2'b00, ST_FILL=2'b01, ST_RUN=2'b10;
  - a length-mask function (len -> MAX_LEN-bit mask of low len ones).
- One sub-module: sat_counter (CNT_W parameter; inputs inc, clr; clr priority; output cnt).
- The detector FSM, history register and compare stay in the top module.

Test Plan:
- Load pat_in=8'b0000_0011 (pattern "011"), pat_len=3, overlap=1; stream 0,1,1,0,1,1 -> match pulses 1 cycle after bits 3 and 6; match_cnt=2.
- Pattern "1011" (pat_in=4'b1011, len 4), stream 1,0,1,1,0,1,1 -> overlap=1: matches after bits 4 and 7, cnt=2. overlap=0: match after bit 4 only, cnt=1.
- Pattern "011" with inp_valid deasserted for 3 cycles between each bit -> match one cycle after the third accepted bit; no match during gaps.
- CNT_W=2, pattern "1", len 1, stream of five 1s -> five match pulses; match_cnt goes 1,2,3,3,3. Then clr_cnt coincident with a match -> cnt=0, match=1.
- pat_load with pat_len=0 -> armed=0, state IDLE; stream 1,1,1 -> no match, cnt unchanged. Then a legal load -> armed=1 next cycle.
- Mid-stream (after "10" of "1011") pulse rst_n low asynchronously between edges -> all outputs 0 immediately, armed=0; a following stream 1,1 gives no match until reload.
